// File: rtl/regfile_drain.sv
// regfile_drain
//   Reads every entry of a 2**ADDR_W deep register file in ascending order.
//   Each word is presented on a valid/ready output stream, and the block
//   keeps a running sum of the words that were transferred.
//   Each word takes two cycles: LOAD captures rd_data into out_data, and
//   SEND offers that word until the consumer accepts it.
// Ports
//   clk, rst         clock; synchronous active-high reset
//   start            drain request, level; sampled only in IDLE/DONE
//   rd_addr/rd_data  register file read port (data is combinational)
//   out_data/out_valid/out_ready/out_last   output stream
//   sum              running sum of transferred words (WIDTH+ADDR_W bits)
//   busy, done       high in LOAD/SEND, and in DONE, respectively
module regfile_drain #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic [WIDTH-1:0]        rd_data,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic [WIDTH+ADDR_W-1:0] sum,
   output logic                    busy,
   output logic                    done
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic              at_last;
   logic              arm;
   logic              xfer;

   assign at_last = (addr == LAST_ADDR);
   assign arm     = ((state == IDLE) || (state == DONE)) && start;
   assign xfer    = (state == SEND) && out_ready;
   assign rd_addr = addr;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = LOAD;
         LOAD:       state_nxt = SEND;
         SEND:       if (out_ready) state_nxt = at_last ? DONE : LOAD;
         default:    state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      out_valid = (state == SEND);
      // addr is frozen while SEND stalls, so out_last holds as well
      out_last  = (state == SEND) && at_last;
      busy      = (state == LOAD) || (state == SEND);
      done      = (state == DONE);
   end

   // datapath: address counter, output word, running sum
   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= '0;
         out_data <= '0;
         sum      <= '0;
      end else begin
         if (arm) begin
            addr <= '0;
            sum  <= '0;
         end
         if (state == LOAD) out_data <= rd_data;
         if (xfer) begin
            // the ADDR_W extra bits hold 2**ADDR_W full-scale words
            sum <= sum + {{ADDR_W{1'b0}}, out_data};
            // stay on the last address so the counter never wraps
            if (!at_last) addr <= addr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_regfile_drain.sv
// Testbench for regfile_drain. The register file is an array inside the
// bench. Each drain is checked against that array: the beats must come in
// order, out_last must mark entry DEPTH-1, the data must stay stable while
// the consumer stalls, and the final sum must match.
module tb_regfile_drain;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int SW     = WIDTH + ADDR_W;

   logic              clk = 1'b0;
   logic              rst, start, out_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data, out_data;
   logic              out_valid, out_last, busy, done;
   logic [SW-1:0]     sum;

   logic [WIDTH-1:0]  mem [DEPTH];
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          pat;       // 0 zeros, 1 i+1, 2 all ones, 3 random
      int          stall_max; // 0 = out_ready always high while valid
      bit          hold;      // start held high through the drain
      bit          chk_time;  // check cycle-exact timing
      logic [SW-1:0] exp_sum;
   } vec_t;

   vec_t          tbl [7];
   logic [SW-1:0] fsum;
   int            nbeats, ncyc, firstv, b, cyc;

   always #5 clk = ~clk;
   assign rd_data = mem[rd_addr];

   regfile_drain #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .sum(sum), .busy(busy), .done(done));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill(input int pat);
      for (int i = 0; i < DEPTH; i++)
         case (pat)
            0:       mem[i] = '0;
            1:       mem[i] = WIDTH'(i + 1);
            2:       mem[i] = '1;
            default: mem[i] = $urandom;
         endcase
   endtask

   // One full drain. It starts from IDLE or DONE and ends with a check of the DONE state.
   task automatic drain(input int stall_max, input bit hold,
                        output logic [SW-1:0] s, output int beats, output int ncy,
                        output int first_v);
      int  bb = 0, cy = 0, stall = 0;
      bit  xf, pend = 0;
      logic [WIDTH-1:0] pd = '0;
      logic pl = 1'b0;
      first_v = -1;
      @(negedge clk); start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1; if (!hold) start = 1'b0;
      if (stall_max > 0) stall = $urandom_range(0, stall_max);
      while (bb < DEPTH && cy < 2000) begin
         @(negedge clk); cy++;
         if (cy == 1) begin
            chk("load_sum_cleared", sum, 0);
            chk("load_done_low", done, 0);
            chk("load_valid_low", out_valid, 0);
            chk("load_addr0", rd_addr, 0);
         end
         chk("busy_in_drain", busy, 1);
         if (pend) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, pd);
            chk("stall_last", out_last, pl);
         end
         if (out_valid) begin
            if (first_v < 0) first_v = cy;
            chk("beat_data", out_data, mem[bb]);
            chk("beat_last", out_last, bb == DEPTH - 1);
            if (out_last && hold) start = 1'b0;
            if (stall > 0) begin out_ready = 1'b0; stall--; end
            else out_ready = 1'b1;
         end else out_ready = 1'($urandom_range(0, 1));
         xf   = out_valid && out_ready;
         pend = out_valid && !out_ready;
         pd   = out_data;
         pl   = out_last;
         @(posedge clk);
         if (xf) begin
            bb++;
            if (stall_max > 0) stall = $urandom_range(0, stall_max);
         end
      end
      #1 out_ready = 1'b0;
      if (bb < DEPTH) chk("drain_timeout_beats", bb, DEPTH);
      @(negedge clk);
      chk("done_high", done, 1);
      chk("busy_low", busy, 0);
      chk("done_valid_low", out_valid, 0);
      s = sum; beats = bb; ncy = cy;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      fill(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sum", sum, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_hold_busy", busy, 0);
      chk("idle_hold_done", done, 0);

      tbl[0] = '{pat: 0, stall_max: 0, hold: 0, chk_time: 1, exp_sum: '0};
      tbl[1] = '{pat: 1, stall_max: 0, hold: 0, chk_time: 1, exp_sum: SW'(136)};
      tbl[2] = '{pat: 2, stall_max: 0, hold: 0, chk_time: 1, exp_sum: 36'hF_FFFF_FFF0};
      tbl[3] = '{pat: 1, stall_max: 5, hold: 0, chk_time: 0, exp_sum: SW'(136)};
      tbl[4] = '{pat: 1, stall_max: 0, hold: 1, chk_time: 1, exp_sum: SW'(136)};
      tbl[5] = '{pat: 3, stall_max: 5, hold: 0, chk_time: 0, exp_sum: '0};
      tbl[6] = '{pat: 3, stall_max: 2, hold: 1, chk_time: 0, exp_sum: '0};

      for (int i = 0; i < 7; i++) begin
         fill(tbl[i].pat);
         if (tbl[i].pat == 3) begin
            tbl[i].exp_sum = '0;
            for (int k = 0; k < DEPTH; k++) tbl[i].exp_sum += SW'(mem[k]);
         end
         drain(tbl[i].stall_max, tbl[i].hold, fsum, nbeats, ncyc, firstv);
         chk("vec_sum", fsum, tbl[i].exp_sum);
         chk("vec_beats", nbeats, DEPTH);
         if (tbl[i].chk_time) begin
            chk("first_valid_cycle", firstv, 2);
            chk("done_cycle", ncyc + 1, 33);
         end
      end

      // DONE holds with start low
      repeat (3) @(negedge clk);
      chk("done_persist", done, 1);
      chk("done_sum_hold", sum, tbl[6].exp_sum);
      chk("done_data_hold", out_data, mem[DEPTH-1]);

      // reset during the SEND cycle of the 5th beat, with start and ready also high
      fill(1);
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      b = 0; cyc = 0;
      while (cyc < 200) begin
         @(negedge clk); cyc++;
         if (out_valid) begin
            if (b == 4) break;
            b++;
         end
      end
      chk("mid_reset_reached_beat5", b, 4);
      rst = 1'b1; start = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_rd_addr", rd_addr, 0);
      chk("mrst_out_data", out_data, 0);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_out_last", out_last, 0);
      chk("mrst_sum", sum, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      rst = 1'b0; start = 1'b0; out_ready = 1'b0;
      drain(3, 1'b0, fsum, nbeats, ncyc, firstv);
      chk("post_rst_sum", fsum, SW'(136));
      chk("post_rst_beats", nbeats, DEPTH);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_drain.md
REGFILE_DRAIN -- requirements
Module: regfile_drain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width of the register file read port and of the output stream.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the address width; DEPTH = 2**ADDR_W entries (16 by default).
REQ-003 Port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  level; request to drain the register file; sampled only in IDLE or DONE.
REQ-006 Port rd_addr  output  ADDR_W  read address driven to the register file read port.
REQ-007 Port rd_data  input  WIDTH  register file read data; combinational from rd_addr, valid in the same cycle.
REQ-008 Port out_data  output  WIDTH  stream data word.
REQ-009 Port out_valid  output  1  out_data is valid.
REQ-010 Port out_ready  input  1  consumer accepts the word; a beat transfers when out_valid && out_ready at a rising edge.
REQ-011 Port out_last  output  1  marks the beat carrying entry DEPTH-1.
REQ-012 Port sum  output  WIDTH+ADDR_W  running sum of all transferred words.
REQ-013 Port busy  output  1  high in the LOAD and SEND states.
REQ-014 Port done  output  1  high in the DONE state.

Function
REQ-015 The block SHALL implement the FSM states IDLE, LOAD, SEND and DONE, with a registered address counter addr and a registered output word.
REQ-016 IDLE/DONE with start=1: go to LOAD, with addr <= 0 and sum <= 0; with start=0, hold the current state.
REQ-017 rd_addr SHALL equal addr at all times.
REQ-018 LOAD: out_data <= rd_data, then go to SEND unconditionally; out_valid=0 during LOAD.
REQ-019 SEND: out_valid=1; out_last=1 iff addr==DEPTH-1.
REQ-020 SEND with out_ready=0: hold the state; out_data, out_last, addr and sum remain unchanged.
REQ-021 SEND with out_ready=1: sum <= sum + out_data, zero-extended, with no overflow possible at WIDTH+ADDR_W bits; then:
  - if addr==DEPTH-1, go to DONE;
  - otherwise addr <= addr+1 and go to LOAD.
REQ-022 Throughput SHALL be at most 1 beat per 2 cycles; start-to-first-out_valid latency SHALL be 2 cycles (IDLE->LOAD edge, LOAD->SEND edge).
REQ-023 Exactly DEPTH beats SHALL be emitted per drain, for addresses 0..DEPTH-1 in ascending order, with no skips or repeats; addr SHALL NOT wrap within a drain.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 DONE: sum and out_data hold their final values; out_valid=0; done stays high until start re-arms a drain (REQ-016) or rst is asserted.
REQ-026 out_valid SHALL never deassert without a transfer once asserted (no retraction).

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE with addr=0, rd_addr=0, out_data=0, out_valid=0, out_last=0, sum=0, busy=0 and done=0, regardless of state, including mid-drain.
REQ-028 rst SHALL take priority over start and out_ready in the same cycle.
REQ-029 After a mid-drain reset, the next start SHALL begin a fresh drain at address 0.

Verification
REQ-030 All 16 entries = 0, out_ready=1, pulse start: 16 beats of 0, out_last only on the 16th beat, sum=0, done=1 at cycle 33 after start.
REQ-031 Entry i = i+1, out_ready=1: beats 1..16 in order, sum=136, busy low and done high after the last beat.
REQ-032 Entries = 0xFFFFFFFF: sum=0xF_FFFFFFF0 (36 bits), no overflow.
REQ-033 out_ready toggling 0/1 with random 0-5 cycle stalls: out_data and out_last stable while stalled, with the same 16 beats and sum as REQ-031.
REQ-034 rst asserted on the 5th beat's SEND cycle: all outputs at reset values the next cycle; a following start yields the full 16-beat drain from address 0.
REQ-035 start held high throughout a drain, then re-pulsed in DONE: the first drain is uninterrupted; the second drain restarts with sum cleared and done low.
